// File: rtl/ber_checker_if.sv
// Symbol/reference strobe bundle and checker status outputs for ber_checker.
interface ber_checker_if #(
    parameter int NB_W    = 8,
    parameter int BUF_LEN = 512,
    parameter int NB_CNT  = 64
);
    localparam int NB_D = $clog2(BUF_LEN);

    logic                     i_enable;
    logic                     i_valid;
    logic signed [NB_W-1:0]   i_ak;
    logic                     i_ref_bit;
    logic                     i_restart;
    logic                     o_locked;
    logic        [NB_D-1:0]   o_delay;
    logic        [NB_CNT-1:0] o_bit_cnt;
    logic        [NB_CNT-1:0] o_err_cnt;

    // master: symbol/reference source; slave: the checker
    modport master (
        output i_enable, i_valid, i_ak, i_ref_bit, i_restart,
        input  o_locked, o_delay, o_bit_cnt, o_err_cnt
    );

    modport slave (
        input  i_enable, i_valid, i_ak, i_ref_bit, i_restart,
        output o_locked, o_delay, o_bit_cnt, o_err_cnt
    );
endinterface

// File: rtl/ber_checker.sv
// Symbol-rate BER checker: slices symbols, searches every reference delay for the
// fewest mismatches, locks on the best one and then counts compared bits and errors.
module ber_checker #(
    parameter int NB_W    = 8,
    parameter int BUF_LEN = 512,
    parameter int WIN     = 511,
    parameter int NB_CNT  = 64
) (
    input logic          i_clk,
    input logic          i_reset,
    ber_checker_if.slave bus
);
    localparam int NB_D  = $clog2(BUF_LEN);
    localparam int NB_WC = $clog2(WIN);
    // one spare bit so the all-ones start value exceeds any window error count
    localparam int ERR_W = $clog2(WIN + 2);

    localparam logic [NB_D-1:0]  FILL_LAST = NB_D'(BUF_LEN - 2);
    localparam logic [NB_D-1:0]  CAND_LAST = NB_D'(BUF_LEN - 1);
    localparam logic [NB_WC-1:0] WIN_LAST  = NB_WC'(WIN - 1);
    localparam logic signed [NB_W-1:0] ZERO = '0;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t               state_q, state_n;
    logic [NB_D-1:0]      fill_q, fill_n;
    logic [NB_D-1:0]      cand_q, cand_n;
    logic [NB_WC-1:0]     win_q, win_n;
    logic [ERR_W-1:0]     err_win_q, err_win_n;
    logic [ERR_W-1:0]     min_err_q, min_err_n;
    logic [NB_D-1:0]      best_q, best_n;
    logic [BUF_LEN-2:0]   ref_sr_q, ref_sr_n;
    logic                 locked_q, locked_n;
    logic [NB_D-1:0]      delay_q, delay_n;
    logic [NB_CNT-1:0]    bit_cnt_q, bit_cnt_n;
    logic [NB_CNT-1:0]    err_cnt_q, err_cnt_n;

    logic                 strobe;
    logic                 dec_bit;
    logic [BUF_LEN-1:0]   hist;
    logic [NB_D-1:0]      tap_sel;
    logic                 mism;
    logic [ERR_W-1:0]     err_sum;
    logic [NB_D-1:0]      best_sel;

    assign strobe  = bus.i_enable & bus.i_valid;
    assign dec_bit = (bus.i_ak < ZERO);

    // hist[d] is the reference bit from d strobes ago (d=0 is the current one)
    assign hist    = {ref_sr_q, bus.i_ref_bit};
    assign tap_sel = (state_q == LOCKED) ? delay_q : cand_q;
    assign mism    = dec_bit ^ hist[tap_sel];
    assign err_sum = err_win_q + ERR_W'(mism);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= FILL;
            fill_q    <= '0;
            cand_q    <= '0;
            win_q     <= '0;
            err_win_q <= '0;
            min_err_q <= '1;
            best_q    <= '0;
            ref_sr_q  <= '0;
            locked_q  <= 1'b0;
            delay_q   <= '0;
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_n;
            fill_q    <= fill_n;
            cand_q    <= cand_n;
            win_q     <= win_n;
            err_win_q <= err_win_n;
            min_err_q <= min_err_n;
            best_q    <= best_n;
            ref_sr_q  <= ref_sr_n;
            locked_q  <= locked_n;
            delay_q   <= delay_n;
            bit_cnt_q <= bit_cnt_n;
            err_cnt_q <= err_cnt_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        fill_n    = fill_q;
        cand_n    = cand_q;
        win_n     = win_q;
        err_win_n = err_win_q;
        min_err_n = min_err_q;
        best_n    = best_q;
        ref_sr_n  = ref_sr_q;
        locked_n  = locked_q;
        delay_n   = delay_q;
        bit_cnt_n = bit_cnt_q;
        err_cnt_n = err_cnt_q;
        best_sel  = best_q;

        if (bus.i_restart) begin
            // restart overrides a coincident strobe, so the history is not shifted
            state_n   = FILL;
            fill_n    = '0;
            cand_n    = '0;
            win_n     = '0;
            err_win_n = '0;
            min_err_n = '1;
            best_n    = '0;
            locked_n  = 1'b0;
            delay_n   = '0;
            bit_cnt_n = '0;
            err_cnt_n = '0;
        end else if (strobe) begin
            ref_sr_n = {ref_sr_q[BUF_LEN-3:0], bus.i_ref_bit};
            unique case (state_q)
                FILL: begin
                    if (fill_q == FILL_LAST) begin
                        state_n   = SEARCH;
                        cand_n    = '0;
                        win_n     = '0;
                        err_win_n = '0;
                    end else begin
                        fill_n = fill_q + 1'b1;
                    end
                end
                SEARCH: begin
                    if (win_q == WIN_LAST) begin
                        if (err_sum < min_err_q) begin
                            min_err_n = err_sum;
                            best_sel  = cand_q;
                        end
                        best_n    = best_sel;
                        err_win_n = '0;
                        win_n     = '0;
                        cand_n    = cand_q + 1'b1;
                        if (cand_q == CAND_LAST) begin
                            state_n   = LOCKED;
                            locked_n  = 1'b1;
                            delay_n   = best_sel;
                            bit_cnt_n = '0;
                            err_cnt_n = '0;
                        end
                    end else begin
                        err_win_n = err_sum;
                        win_n     = win_q + 1'b1;
                    end
                end
                LOCKED: begin
                    // err_cnt never exceeds bit_cnt, so freezing on bit_cnt saturates both
                    if (bit_cnt_q != '1) begin
                        bit_cnt_n = bit_cnt_q + 1'b1;
                        err_cnt_n = err_cnt_q + NB_CNT'(mism);
                    end
                end
                default: state_n = FILL;
            endcase
        end
    end

    assign bus.o_locked  = locked_q;
    assign bus.o_delay   = delay_q;
    assign bus.o_bit_cnt = bit_cnt_q;
    assign bus.o_err_cnt = err_cnt_q;
endmodule
